// File: rtl/sprite_mem_arbiter_if.sv
// Sprite memory arbiter bus interface.
// Bundles the requester handshake (req/addr/elem -> gnt, rsp_valid/rsp_data)
// and the sprite memory read port (read_enable/address/element <- dataout).
//   slave  : arbiter view (drives gnt, responses and the memory request)
//   master : environment view (requesters plus the memory itself)
interface sprite_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int ELEM_W  = 3,
    parameter int DATA_W  = 12
);
    logic                      video_active;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*ELEM_W-1:0] req_elem;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      mem_read_enable;
    logic [ADDR_W-1:0]         mem_address;
    logic [ELEM_W-1:0]         mem_element;
    logic [DATA_W-1:0]         mem_dataout;

    modport slave (
        input  video_active, req, req_addr, req_elem, mem_dataout,
        output gnt, rsp_valid, rsp_data, mem_read_enable, mem_address, mem_element
    );

    modport master (
        output video_active, req, req_addr, req_elem, mem_dataout,
        input  gnt, rsp_valid, rsp_data, mem_read_enable, mem_address, mem_element
    );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// Sprite memory read-port arbiter.
// Shares one sprite memory read port between NUM_REQ requesters. Requester 0
// (pixel renderer) has hard priority while video_active is high; the others
// are served round-robin, and any low-priority requester denied STARVE_LIMIT
// consecutive cycles is forced through. Returned data is routed back with a
// one-hot rsp_valid strobe MEM_LATENCY+1 cycles after the accepting edge.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : sprite_mem_arbiter_if.slave (requester handshake + memory port)
// Optional (macro ARB_STATS_EN):
//   grant_count   : per-requester saturating 16-bit grant counters
//   starve_events : saturating count of forced starvation grants
module sprite_mem_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 10,
    parameter int ELEM_W       = 3,
    parameter int DATA_W       = 12,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    sprite_mem_arbiter_if.slave     bus
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   grant_count,
    output logic [15:0]             starve_events
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] PTR_RST = (NUM_REQ > 1) ? PTR_W'(1) : '0;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   starve_q [NUM_REQ];
    logic [CNT_W-1:0]   starve_d [NUM_REQ];
    logic [NUM_REQ-1:0] tag_q [MEM_LATENCY+1];
    logic [NUM_REQ-1:0] tag_d [MEM_LATENCY+1];
    logic               mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ELEM_W-1:0]  mem_elem_q, mem_elem_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win_idx;
    logic               forced, pri0_win, rr_win, have_win;
    int                 idx;

    // Winner selection. Loops run from high to low so the last match is the
    // lowest index (forced) or the smallest offset from the pointer (RR).
    always_comb begin
        forced   = 1'b0;
        pri0_win = 1'b0;
        rr_win   = 1'b0;
        win_idx  = '0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            if (bus.req[i] && (starve_q[i] == CNT_MAX)) begin
                forced  = 1'b1;
                win_idx = PTR_W'(i);
            end
        end
        if (!forced) begin
            if (bus.video_active && bus.req[0]) begin
                pri0_win = 1'b1;
                win_idx  = '0;
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    if (bus.req[idx]) begin
                        rr_win  = 1'b1;
                        win_idx = PTR_W'(idx);
                    end
                end
            end
        end
        have_win = forced | pri0_win | rr_win;
        gnt = '0;
        // No grant while reset is held: a requester must not see a transfer
        // that the flopped issue stage is about to discard.
        if (have_win && !reset) gnt[win_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_win && !reset)
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

        starve_d[0] = '0;
        for (int i = 1; i < NUM_REQ; i++) begin
            if (bus.req[i] && !gnt[i])
                starve_d[i] = (starve_q[i] == CNT_MAX) ? CNT_MAX : starve_q[i] + CNT_W'(1);
            else
                starve_d[i] = '0;
        end

        mem_re_d   = |gnt;
        mem_addr_d = mem_addr_q;
        mem_elem_d = mem_elem_q;
        if (|gnt) begin
            mem_addr_d = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_elem_d = bus.req_elem[win_idx*ELEM_W +: ELEM_W];
        end

        // Entry 0 rides alongside the issued address; the last entry lines up
        // with valid mem_dataout and feeds the response register.
        tag_d[0] = gnt;
        for (int j = 1; j <= MEM_LATENCY; j++) tag_d[j] = tag_q[j-1];

        rsp_valid_d = tag_q[MEM_LATENCY];
        rsp_data_d  = (|tag_q[MEM_LATENCY]) ? bus.mem_dataout : rsp_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= PTR_RST;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_elem_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= '0;
            for (int j = 0; j <= MEM_LATENCY; j++) tag_q[j] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_elem_q  <= mem_elem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= starve_d[i];
            for (int j = 0; j <= MEM_LATENCY; j++) tag_q[j] <= tag_d[j];
        end
    end

    assign bus.gnt             = gnt;
    assign bus.mem_read_enable = mem_re_q;
    assign bus.mem_address     = mem_addr_q;
    assign bus.mem_element     = mem_elem_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;

`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] starve_ev_q, starve_ev_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            grant_cnt_d[i] = (gnt[i] && (grant_cnt_q[i] != 16'hFFFF)) ?
                             grant_cnt_q[i] + 16'd1 : grant_cnt_q[i];
        starve_ev_d = (forced && (|gnt) && (starve_ev_q != 16'hFFFF)) ?
                      starve_ev_q + 16'd1 : starve_ev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            starve_ev_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
            starve_ev_q <= starve_ev_d;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_count[i*16 +: 16] = grant_cnt_q[i];
    end
    assign starve_events = starve_ev_q;
`endif
endmodule

// File: doc/sprite_mem_arbiter.md
Name: sprite_mem_arbiter

Overview:
Shares the single read port of the sprite memory between several requesters: the pixel renderer (requester 0), the phrase/text overlay and background/utility fetchers. Picks one request per cycle, drives the memory's read_enable/address_sprite/element, and routes the returned 12-bit pixel colour back to the winner with a one-hot response strobe. Requester 0 gets hard priority during active video. A starvation guard keeps the other requesters served.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 10, sprite address width
ELEM_W, 3, element select width
DATA_W, 12, memory data width (RGB 4:4:4)
MEM_LATENCY, 1, cycles from registered address to valid mem_dataout (1..4)
STARVE_LIMIT, 15, consecutive denials of a pending low-priority request before it is forced

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
video_active  in  1  active display area; enables requester-0 priority
req  in  NUM_REQ  request per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_elem  in  NUM_REQ*ELEM_W  packed element selects
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted req
rsp_valid  out  NUM_REQ  one-hot, data-valid strobe for the requester owning rsp_data
rsp_data  out  DATA_W  returned colour word
mem_read_enable  out  1  to memory read_enable
mem_address  out  ADDR_W  to memory address_sprite
mem_element  out  ELEM_W  to memory element
mem_dataout  in  DATA_W  from memory dataout

Behaviour:
- Reset (async) drives all outputs to 0: mem_read_enable, mem_address, mem_element, rsp_valid, rsp_data. RR pointer = 1, starvation counters = 0, in-flight tag pipe cleared.
- Handshake: requester holds req/addr/elem stable until it sees gnt[i]=1 at a clk edge. Transfer happens when req[i] & gnt[i]. At most one gnt bit is high. gnt is 0 when req is 0.
- Arbitration order each cycle:
  1. Any requester i>0 whose starve_cnt[i] == STARVE_LIMIT and req[i]=1 wins. Lowest index breaks ties.
  2. Otherwise, if video_active=1 and req[0]=1, requester 0 wins.
  3. Otherwise round-robin over all requesters, starting at the RR pointer.
- RR pointer advances to (winner+1) mod NUM_REQ only on a round-robin win (case 3).
- starve_cnt[i] (i>0): increments, saturating at STARVE_LIMIT, when req[i]=1 and gnt[i]=0. Clears on gnt[i] or req[i]=0. Width is clog2(STARVE_LIMIT+1).
- Issue stage: on the clk edge after a grant, mem_address/mem_element take the winner's values, mem_read_enable=1, and the winner's one-hot tag enters a MEM_LATENCY-deep tag pipe. With no grant, mem_read_enable=0 and mem_address/mem_element hold their values.
- Return: rsp_valid = tag pipe output, registered together with rsp_data = mem_dataout. Total latency from accepted req edge to rsp_valid is MEM_LATENCY+1 cycles (2 at default).
- Fully pipelined: one accepted request per cycle. Back-to-back grants to the same requester are allowed.
- Data returns in issue order; rsp_valid is never suppressed once issued.
- rsp_data holds its last value while rsp_valid=0.
- video_active toggling mid-request only affects arbitration from that cycle on. In-flight reads are unaffected.
- Reset mid-operation: the tag pipe flushes and nothing returns for the aborted reads. The first grant after release needs reset=0 at the edge.
- NUM_REQ=1: gnt=req, no starvation logic.

Optional Feature:
ARB_STATS_EN
- Defined: adds output grant_count (NUM_REQ*16). Per-requester 16-bit counters increment on each req&gnt and saturate at 16'hFFFF. Adds output starve_events (16), which increments each time a forced starvation grant occurs. All counters clear on reset.
- Undefined: these ports and registers are absent, and the arbitration behaviour is identical.

Test Plan:
- Reset, then req=3'b001, addr0=10'h005, video_active=1, mem returns 12'hABC → gnt=001 same cycle; mem_read_enable=1, mem_address=0x005 next edge; rsp_valid=001, rsp_data=0xABC 2 cycles after accept.
- video_active=0, req=3'b111 held 6 cycles → grants cycle 1,2,0,1,2,0 (pointer starts at 1); rsp_valid sequence lags by 2 cycles with matching data.
- video_active=1, req=3'b111 held 40 cycles → requester 0 granted except forced grants: req1 on cycle 16, req2 on cycle 17 (STARVE_LIMIT=15 reached; req1 wins the tie on cycle 16).
- Issue 3 back-to-back reads (req0 addr 1,2,3), then assert reset for 1 cycle at the edge after the 2nd accept → no further rsp_valid, all outputs 0, next read returns correctly after MEM_LATENCY+1.
- MEM_LATENCY=3, alternating req1/req2 streaming → one rsp_valid per cycle, 4-cycle latency, order preserved.
- ARB_STATS_EN defined, 70000 grants to req0 → grant_count[0]=16'hFFFF, others 0.
